// File: rtl/johnson_dec_chk.sv
// Johnson-code receive checker: decodes a sampled Johnson bus to a state index and tracks
// code legality, sequence continuity, lock status and a saturating sequence-error count.
module johnson_dec_chk #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] jc_in,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [IDX_W-1:0] idx,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned SeqLen = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SeqLen - 1);
  localparam logic [3:0] LockTarget = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       run_q, run_d;
  logic [IDX_W-1:0] prev_q, prev_d;

  logic             desc_ok, asc_ok, legal;
  int unsigned      pop;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] prev_succ;
  logic             is_hold, is_adv;
  logic             err_event;

  // Legal codes are monotone along the bit order: ones packed at bit0 or at the MSB.
  always_comb begin
    desc_ok = 1'b1;
    asc_ok  = 1'b1;
    pop     = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + 32'(jc_in[i]);
    end
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      if (jc_in[i+1] && !jc_in[i]) desc_ok = 1'b0;
      if (jc_in[i] && !jc_in[i+1]) asc_ok = 1'b0;
    end
    legal   = desc_ok | asc_ok;
    dec_idx = jc_in[WIDTH-1] ? IDX_W'(SeqLen - pop) : IDX_W'(pop);
  end

  assign prev_succ = (prev_q == LastIdx) ? '0 : prev_q + IDX_W'(1);
  assign is_hold   = (dec_idx == prev_q);
  assign is_adv    = (dec_idx == prev_succ);

  always_comb begin
    state_d     = state_q;
    valid_d     = in_valid;
    idx_d       = idx_q;
    illegal_d   = illegal_q;
    seq_err_d   = 1'b0;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    prev_d      = prev_q;
    err_event   = 1'b0;

    if (in_valid) begin
      if (!legal) begin
        illegal_d   = 1'b1;
        idx_d       = '0;
        have_prev_d = 1'b0;
        run_d       = '0;
        if (state_q == StLocked) begin
          err_event = 1'b1;
          state_d   = StUnlocked;
        end
      end else begin
        illegal_d   = 1'b0;
        idx_d       = dec_idx;
        prev_d      = dec_idx;
        have_prev_d = 1'b1;
        // Without a reference the sample only seeds prev_idx.
        if (have_prev_q) begin
          unique case (state_q)
            StLocked: begin
              if (!is_hold && !is_adv) begin
                err_event = 1'b1;
                state_d   = StUnlocked;
                run_d     = '0;
              end
            end
            StUnlocked: begin
              if (is_adv) begin
                if (run_q + 4'd1 == LockTarget) begin
                  state_d = StLocked;
                  run_d   = '0;
                end else begin
                  run_d = run_q + 4'd1;
                end
              end else if (!is_hold) begin
                run_d = '0;
              end
            end
            default: state_d = StUnlocked;
          endcase
        end
      end
    end

    seq_err_d = err_event;

    if (clr_err) begin
      err_d = err_event ? ERR_W'(1) : '0;
    end else if (err_event && err_q != ErrMax) begin
      err_d = err_q + ERR_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StUnlocked;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_q       <= '0;
      have_prev_q <= 1'b0;
      run_q       <= '0;
      prev_q      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      err_q       <= err_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
    end
  end

  assign out_valid = valid_q;
  assign idx       = idx_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == StLocked);
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_johnson_dec_chk.sv
// Bench for johnson_dec_chk: directed vector table, randomized run against a lookup-table
// model, error-counter saturation/clear and asynchronous reset sequences.
module tb_johnson_dec_chk;

  localparam int LockN = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] jc_in = '0;
  logic       clr_err = 1'b0;
  logic       out_valid;
  logic [2:0] idx;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  johnson_dec_chk #(
    .WIDTH(4),
    .IDX_W(3),
    .LOCK_CNT(LockN),
    .ERR_W(8)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .in_valid (in_valid),
    .jc_in    (jc_in),
    .clr_err  (clr_err),
    .out_valid(out_valid),
    .idx      (idx),
    .illegal  (illegal),
    .seq_err  (seq_err),
    .locked   (locked),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: code table lookup plus modular step arithmetic.
  logic [3:0] jtab [8];
  int m_ov, m_idx, m_ill, m_se, m_lk, m_err, m_run, m_hp, m_prev;

  task automatic model_reset();
    m_ov = 0; m_idx = 0; m_ill = 0; m_se = 0; m_lk = 0;
    m_err = 0; m_run = 0; m_hp = 0; m_prev = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c, input logic clr);
    int k, step, inc;
    k = -1;
    inc = 0;
    m_ov = int'(v);
    if (v) begin
      for (int j = 0; j < 8; j++) if (jtab[j] == c) k = j;
      if (k < 0) begin
        m_ill = 1; m_idx = 0; m_hp = 0; m_run = 0;
        if (m_lk != 0) begin inc = 1; m_lk = 0; end
      end else begin
        m_ill = 0;
        m_idx = k;
        if (m_hp != 0) begin
          step = (k - m_prev + 8) % 8;
          if (m_lk != 0) begin
            if (step > 1) begin inc = 1; m_lk = 0; m_run = 0; end
          end else if (step == 1) begin
            m_run++;
            if (m_run == LockN) begin m_lk = 1; m_run = 0; end
          end else if (step != 0) begin
            m_run = 0;
          end
        end
        m_prev = k;
        m_hp = 1;
      end
    end
    m_se = inc;
    if (clr) m_err = inc;
    else if (inc != 0 && m_err < 255) m_err++;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), m_ov);
    chk({tag, ".idx"}, int'(idx), m_idx);
    chk({tag, ".illegal"}, int'(illegal), m_ill);
    chk({tag, ".seq_err"}, int'(seq_err), m_se);
    chk({tag, ".locked"}, int'(locked), m_lk);
    chk({tag, ".err_cnt"}, int'(err_cnt), m_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out_valid"}, int'(out_valid), 0);
    chk({tag, ".idx"}, int'(idx), 0);
    chk({tag, ".illegal"}, int'(illegal), 0);
    chk({tag, ".seq_err"}, int'(seq_err), 0);
    chk({tag, ".locked"}, int'(locked), 0);
    chk({tag, ".err_cnt"}, int'(err_cnt), 0);
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic clr);
    in_valid = v;
    jc_in    = c;
    clr_err  = clr;
    @(posedge clk);
    model_step(v, c, clr);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] code;
    logic       clr;
    int         ov, ix, ill, se, lk, err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] c, input logic clr,
                     input int ov, input int ix, input int ill, input int se,
                     input int lk, input int err);
    vec_t e;
    e.v = v; e.code = c; e.clr = clr;
    e.ov = ov; e.ix = ix; e.ill = ill; e.se = se; e.lk = lk; e.err = err;
    tbl.push_back(e);
  endtask

  // Drives a reference plus four advances from code 0000, which locks from any unlocked state.
  task automatic lock_up();
    drive(1'b1, 4'b0000, 1'b0); chk_model("lk0");
    drive(1'b1, 4'b0001, 1'b0); chk_model("lk1");
    drive(1'b1, 4'b0011, 1'b0); chk_model("lk2");
    drive(1'b1, 4'b0111, 1'b0); chk_model("lk3");
    drive(1'b1, 4'b1111, 1'b0); chk_model("lk4");
  endtask

  initial begin
    int cur;
    int r;
    logic v;
    logic [3:0] c;
    string tg;

    for (int k = 0; k < 4; k++) jtab[k] = 4'((1 << k) - 1);
    for (int k = 4; k < 8; k++) jtab[k] = 4'(4'hF << (k - 4));
    model_reset();

    // Sequences: lock, wrap, hold with gaps, jump relock, illegal then reference-only.
    add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 0, 0);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 0, 0);
    add(1, 4'b0111, 0, 1, 3, 0, 0, 0, 0);
    add(1, 4'b1111, 0, 1, 4, 0, 0, 1, 0);
    add(1, 4'b1110, 0, 1, 5, 0, 0, 1, 0);
    add(1, 4'b1100, 0, 1, 6, 0, 0, 1, 0);
    add(1, 4'b1000, 0, 1, 7, 0, 0, 1, 0);
    add(1, 4'b0000, 0, 1, 0, 0, 0, 1, 0);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 1, 0);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 1, 0);
    add(0, 4'b0000, 0, 0, 2, 0, 0, 1, 0);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 1, 0);
    add(0, 4'b1010, 0, 0, 2, 0, 0, 1, 0);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 1, 0);
    add(1, 4'b0111, 0, 1, 3, 0, 0, 1, 0);
    add(1, 4'b1100, 0, 1, 6, 0, 1, 0, 1);
    add(1, 4'b1000, 0, 1, 7, 0, 0, 0, 1);
    add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 1);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 0, 1);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 1, 1);
    add(1, 4'b0101, 0, 1, 0, 1, 1, 0, 2);
    add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 2);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 0, 2);
    add(1, 4'b0011, 0, 1, 2, 0, 0, 0, 2);
    add(1, 4'b0111, 0, 1, 3, 0, 0, 0, 2);
    add(1, 4'b1111, 0, 1, 4, 0, 0, 1, 2);
    add(0, 4'b0000, 1, 0, 4, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk_zero("post_reset");

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].code, tbl[i].clr);
      tg = $sformatf("vec%0d", i);
      chk({tg, ".out_valid"}, int'(out_valid), tbl[i].ov);
      chk({tg, ".idx"}, int'(idx), tbl[i].ix);
      chk({tg, ".illegal"}, int'(illegal), tbl[i].ill);
      chk({tg, ".seq_err"}, int'(seq_err), tbl[i].se);
      chk({tg, ".locked"}, int'(locked), tbl[i].lk);
      chk({tg, ".err_cnt"}, int'(err_cnt), tbl[i].err);
    end

    // Randomized traffic, biased toward advancing so lock is reached and lost repeatedly.
    cur = 4;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom % 4) != 0;
      r = int'($urandom % 16);
      if (r < 10) cur = (cur + 1) % 8;
      else if (r < 12) cur = cur;
      else if (r < 14) cur = int'($urandom % 8);
      c = jtab[cur];
      if (r >= 14) c = 4'($urandom);
      drive(v, c, ($urandom % 25) == 0);
      chk_model($sformatf("rnd%0d", n));
    end

    // Push the error counter past saturation.
    for (int n = 0; n < 260; n++) begin
      lock_up();
      drive(1'b1, 4'b0101, 1'b0);
      chk_model("sat_err");
    end
    chk("sat.err_cnt", int'(err_cnt), 255);

    lock_up();
    drive(1'b1, 4'b1010, 1'b1);
    chk_model("clr_evt");
    chk("clr_evt.err_cnt", int'(err_cnt), 1);
    chk("clr_evt.seq_err", int'(seq_err), 1);
    drive(1'b0, 4'b0000, 1'b1);
    chk("clr_only.err_cnt", int'(err_cnt), 0);

    // Asynchronous reset while locked with errors pending.
    lock_up();
    drive(1'b1, 4'b0101, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("mid_reset_hold");
    @(negedge clk);
    n_rst = 1'b1;
    drive(1'b1, 4'b0011, 1'b0);
    chk_model("after_reset");
    lock_up();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
